// File: rtl/bi_buf_pkg.sv
// bi_buf_pkg: shared definitions for the registered bidirectional buffer.
//   BI_BUF_WIDTH  default data width of all bi_buf data ports
//   bi_buf_dir_e  transfer direction, encoded to match the en input
package bi_buf_pkg;

  localparam int BI_BUF_WIDTH = 8;

  typedef enum logic {
    DIR_D2B = 1'b0,  // data side -> bus side (d_in to buf_out)
    DIR_B2D = 1'b1   // bus side -> data side (buf_in to d_out)
  } bi_buf_dir_e;

endpackage

// File: rtl/bi_buf_reg.sv
// bi_buf_reg: WIDTH-bit register with synchronous reset-to-zero and load enable.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, has priority over load
//   load  when high, d is captured on the next rising edge; otherwise q holds
//   d     data input
//   q     registered data output
module bi_buf_reg
  import bi_buf_pkg::*;
#(
  parameter int WIDTH = BI_BUF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/bi_buf.sv
// bi_buf: registered bidirectional buffer between a bus side (buf_*) and a
// data side (d_*). en selects the direction sampled at each rising edge; the
// selected input is copied into the opposite side's output register while the
// other output holds.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (outputs and direction to 0)
//   en       direction select: 0 = d_in -> buf_out, 1 = buf_in -> d_out
//   buf_in   bus-side input
//   d_in     data-side input
//   buf_out  bus-side output, registered
//   d_out    data-side output, registered
// Configuration:
//   BI_BUF_TURNAROUND_EN  when defined, a direction change costs one bubble
//                         edge on which neither output updates. When
//                         undefined, direction changes take effect at once.
module bi_buf
  import bi_buf_pkg::*;
#(
  parameter int WIDTH = BI_BUF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] buf_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] buf_out,
  output logic [WIDTH-1:0] d_out
);

  logic load_d2b;
  logic load_b2d;

`ifdef BI_BUF_TURNAROUND_EN
  bi_buf_dir_e dir_q;
  bi_buf_dir_e dir_d;
  logic        bubble;

  // The stored direction always follows the sampled en; a mismatch between
  // the two marks the turnaround edge, which blocks both loads.
  always_comb begin
    dir_d    = bi_buf_dir_e'(en);
    bubble   = (dir_d != dir_q);
    load_d2b = !bubble && (dir_d == DIR_D2B);
    load_b2d = !bubble && (dir_d == DIR_B2D);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= DIR_D2B;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  always_comb begin
    load_d2b = (bi_buf_dir_e'(en) == DIR_D2B);
    load_b2d = (bi_buf_dir_e'(en) == DIR_B2D);
  end
`endif

  bi_buf_reg #(.WIDTH(WIDTH)) u_d2b_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load_d2b),
    .d    (d_in),
    .q    (buf_out)
  );

  bi_buf_reg #(.WIDTH(WIDTH)) u_b2d_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load_b2d),
    .d    (buf_in),
    .q    (d_out)
  );

endmodule

// File: tb/tb_bi_buf.sv
// tb_bi_buf: scoreboard bench for bi_buf. The driver applies one stimulus
// vector per cycle, advances a behavioural model and queues the outputs
// expected after the next edge; the monitor pops and compares one entry
// after every edge. Directed test-plan vectors come first, then random ones.
module tb_bi_buf;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] buf_in;
  logic [W-1:0] d_in;
  logic [W-1:0] buf_out;
  logic [W-1:0] d_out;

  always #5 clk = ~clk;

  bi_buf #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .buf_in  (buf_in),
    .d_in    (d_in),
    .buf_out (buf_out),
    .d_out   (d_out)
  );

  typedef struct {
    int           idx;
    logic [W-1:0] exp_buf;
    logic [W-1:0] exp_d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_vec = 0;

  // Reference model state: what each output should hold, and which
  // direction the buffer believes it is in (only meaningful with turnaround).
  logic [W-1:0] ref_buf = '0;
  logic [W-1:0] ref_d   = '0;
  int           ref_dir = 0;

  function automatic void model_step(input logic r, input logic e,
                                     input logic [W-1:0] bi, input logic [W-1:0] di);
    bit transfer;
    if (r) begin
      ref_buf = '0;
      ref_d   = '0;
      ref_dir = 0;
      return;
    end
    transfer = 1'b1;
`ifdef BI_BUF_TURNAROUND_EN
    if (int'(e) != ref_dir) begin
      ref_dir  = int'(e);
      transfer = 1'b0;
    end
`endif
    if (transfer) begin
      if (e) ref_d = bi;
      else   ref_buf = di;
    end
  endfunction

  // One cycle of stimulus. Inputs change 2 time units after the rising edge;
  // with glitch set, en is pulsed to the opposite value between edges.
  task automatic drive(input logic r, input logic e, input logic [W-1:0] bi,
                       input logic [W-1:0] di, input bit glitch);
    exp_t x;
    @(posedge clk);
    #2;
    rst    = r;
    en     = e;
    buf_in = bi;
    d_in   = di;
    model_step(r, e, bi, di);
    x.idx     = n_vec;
    x.exp_buf = ref_buf;
    x.exp_d   = ref_d;
    sb.push_back(x);
    n_vec++;
    if (glitch) begin
      #2 en = ~e;
      #1 en = e;
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total++;
        if (buf_out !== x.exp_buf) begin
          bad++;
          $display("FAIL buf_out vec=%0d got=%h exp=%h", x.idx, buf_out, x.exp_buf);
        end
        total++;
        if (d_out !== x.exp_d) begin
          bad++;
          $display("FAIL d_out vec=%0d got=%h exp=%h", x.idx, d_out, x.exp_d);
        end
        $display("vec=%0d buf_out=%h d_out=%h exp_buf=%h exp_d=%h",
                 x.idx, buf_out, d_out, x.exp_buf, x.exp_d);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst    = 1'b1;
    en     = 1'b0;
    buf_in = '0;
    d_in   = '0;

    // Reset held with all-ones inputs.
    drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
    drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
    // Data-to-bus; d_out must ignore 8'h6D.
    drive(1'b0, 1'b0, 8'h6D, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h6D, 8'hA5, 1'b0);
    drive(1'b0, 1'b0, 8'h6D, 8'hA5, 1'b0);
    // Switch to bus-to-data (bubble edge when turnaround is enabled).
    drive(1'b0, 1'b1, 8'h6D, 8'hA5, 1'b0);
    drive(1'b0, 1'b1, 8'h6D, 8'hA5, 1'b0);
    // Back-to-back change of both inputs; d_in is ignored.
    drive(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    // en glitch between edges must not disturb anything.
    drive(1'b0, 1'b1, 8'h5A, 8'h11, 1'b1);
    drive(1'b0, 1'b0, 8'h22, 8'hC3, 1'b1);
    // Reset priority over en and data.
    drive(1'b1, 1'b1, 8'h3C, 8'h3C, 1'b0);
    // Toggle stress: en alternates every cycle, incrementing data.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, logic'(i % 2 == 0), W'(8'h10 + i), W'(8'h80 + i), 1'b0);
    end
    // Randomised traffic with runs of stable direction and rare resets.
    for (int i = 0; i < 300; i++) begin
      logic r, e;
      r = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 3) == 0) ? ~en : en;
      drive(r, e, W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
